// File: rtl/mouse_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send,
// shifts out one odd-parity frame on device clock edges and checks the ACK.
module mouse_transmitter #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 100,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT_EN,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic [1:0] ERROR_CODE,
  output logic [2:0] STATE
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_INHIBIT    = 3'd1;
  localparam logic [2:0] S_REQ        = 3'd2;
  localparam logic [2:0] S_START_WAIT = 3'd3;
  localparam logic [2:0] S_SEND       = 3'd4;
  localparam logic [2:0] S_ACK_WAIT   = 3'd5;
  localparam logic [2:0] S_IDLE_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE       = 3'd7;

  localparam int T_MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int T_MAX_B = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] REQ_LAST   = TW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TIMEOUT - 1);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [9:0]    sreg;
  logic [3:0]    edge_cnt;
  logic [1:0]    err;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      timer    <= '0;
      sreg     <= '0;
      edge_cnt <= '0;
      err      <= '0;
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      data_s1  <= 1'b0;
      data_s2  <= 1'b0;
    end else begin
      clk_s1   <= CLK_MOUSE_IN;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= DATA_MOUSE_IN;
      data_s2  <= data_s1;
      timer    <= timer + TW'(1);
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (SEND_BYTE) begin
            sreg     <= {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND};
            err      <= 2'b00;
            edge_cnt <= '0;
            state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: if (timer == INH_LAST) begin
          state <= S_REQ;
          timer <= '0;
        end
        S_REQ: if (timer == REQ_LAST) begin
          state <= S_START_WAIT;
          timer <= '0;
        end
        S_START_WAIT: begin
          if (fall) begin
            state    <= S_SEND;
            edge_cnt <= 4'd1;
            timer    <= '0;
          end else if (timer == START_LAST) begin
            err[0] <= 1'b1;
            state  <= S_DONE;
          end
        end
        // Each device edge advances the frame; the tenth edge presents stop.
        S_SEND: begin
          if (fall) begin
            timer <= '0;
            sreg  <= {1'b0, sreg[9:1]};
            if (edge_cnt == 4'd9) begin
              edge_cnt <= 4'd10;
              state    <= S_ACK_WAIT;
            end else begin
              edge_cnt <= edge_cnt + 4'd1;
            end
          end else if (timer == BIT_LAST) begin
            err[0] <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_ACK_WAIT: begin
          if (fall) begin
            err[1] <= data_s2;
            state  <= S_IDLE_WAIT;
            timer  <= '0;
          end else if (timer == BIT_LAST) begin
            err[0] <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_IDLE_WAIT: begin
          if (clk_s2 && data_s2) begin
            state <= S_DONE;
          end else if (timer == BIT_LAST) begin
            err[0] <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset releases the lines at once.
  always_comb begin
    CLK_MOUSE_OUT_EN  = (state == S_INHIBIT) || (state == S_REQ);
    DATA_MOUSE_OUT_EN = (state == S_REQ) || (state == S_START_WAIT) ||
                        ((state == S_SEND) && !sreg[0]);
    BUSY              = (state != S_IDLE);
    BYTE_SENT         = (state == S_DONE);
    ERROR_CODE        = err;
    STATE             = state;
  end

endmodule

// File: doc/mouse_transmitter.md
Name: mouse_transmitter

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting) from the mouse master FSM to the mouse. The sequence is: clock inhibit, request-to-send, 11-bit frame clocked by the device, then device ACK check. It shares the PS/2 CLK/DATA lines with the existing receiver. The top level converts the *_OUT_EN outputs into open-drain tristates.

Parameters:
INHIBIT_CYCLES, 6000, CLK cycles the mouse clock is held low (120 us at 50 MHz).
REQ_CYCLES, 100, cycles data and clock are both held low before the clock is released (2 us).
START_TIMEOUT, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
BIT_TIMEOUT, 100000, maximum cycles between consecutive device falling edges (2 ms).

Ports:
CLK  in  1  system clock, 50 MHz.
RESET  in  1  asynchronous, active-low reset.
CLK_MOUSE_IN  in  1  PS/2 clock line as sensed at the pin.
DATA_MOUSE_IN  in  1  PS/2 data line as sensed at the pin.
SEND_BYTE  in  1  one-cycle request; honoured only when BUSY=0.
BYTE_TO_SEND  in  8  command byte; sampled on the cycle SEND_BYTE is accepted.
CLK_MOUSE_OUT_EN  out  1  1 = drive the PS/2 clock low; 0 = release.
DATA_MOUSE_OUT_EN  out  1  1 = drive PS/2 data low; 0 = release (line reads 1).
BUSY  out  1  high from SEND_BYTE acceptance until the cycle of the BYTE_SENT pulse, inclusive.
BYTE_SENT  out  1  one-cycle pulse when the transfer ends, whether successful or failed.
ERROR_CODE  out  2  bit0 = timeout, bit1 = no ACK; valid with BYTE_SENT and held until the next accept.

Behaviour:
- Reset (RESET=0, async):
  - state IDLE.
  - All outputs 0: both lines released, BUSY=0, BYTE_SENT=0, ERROR_CODE=00.
  - Shift register, counters and synchronisers cleared.
  - Reset mid-transfer releases both lines immediately, without waiting for a clock edge.
- Input synchronisation and edge detection:
  - CLK_MOUSE_IN and DATA_MOUSE_IN each pass through a 2-flop synchroniser.
  - A device falling edge is detected when the previous synchronised clock is 1 and the current synchronised clock is 0.
- Frame: shift register = {stop=1, parity, byte[7:0]}, sent LSB first.
  - parity = ~^BYTE_TO_SEND (odd parity).
  - DATA_MOUSE_OUT_EN = ~current bit.
- States (all on posedge CLK):
  - IDLE: on SEND_BYTE, latch the byte, clear ERROR_CODE, BUSY=1, go to INHIBIT.
  - INHIBIT: CLK_EN=1, DATA_EN=0 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: CLK_EN=1, DATA_EN=1 (start bit) for REQ_CYCLES cycles, then go to START_WAIT.
  - START_WAIT: CLK_EN=0, DATA_EN=1. On a falling edge, present bit0, edge count=1, go to SEND. No edge within START_TIMEOUT → set ERROR_CODE[0], go to DONE.
  - SEND: on each falling edge, present the next frame bit.
    - Edges 1..8 present byte bits 0..7.
    - Edge 9 presents parity.
    - Edge 10 presents stop (DATA_EN=0); then go to ACK_WAIT.
    - The bit timer is cleared on every edge. It reaching BIT_TIMEOUT → set ERROR_CODE[0], go to DONE.
  - ACK_WAIT: lines released. On the next falling edge, sample synchronised data: 0 → ACK OK, 1 → set ERROR_CODE[1]. Then go to IDLE_WAIT. Timeout → ERROR_CODE[0], go to DONE.
  - IDLE_WAIT: wait until both synchronised lines are 1 (device released ACK), then go to DONE. Timeout → ERROR_CODE[0], go to DONE.
  - DONE: BYTE_SENT=1 for one cycle, go to IDLE. BUSY drops the cycle after DONE.
- Line release on failure: every timeout or error path releases both lines within 1 cycle.
- Busy requests: SEND_BYTE while BUSY=1 is ignored. It is neither queued nor allowed to change the latched byte.
- Timeout counter width: covers START_TIMEOUT; it is restarted on every state entry.
- Simultaneous SEND_BYTE and DONE: the request is ignored, because BUSY is still 1 that cycle.
- Spurious edges: falling edges seen in IDLE, INHIBIT or REQ are ignored.

Test Plan:
- Reset and idle: assert RESET=0 mid-REQ → CLK_MOUSE_OUT_EN=0, DATA_MOUSE_OUT_EN=0, BUSY=0 and ERROR_CODE=00 asynchronously. After release, no activity until SEND_BYTE.
- Send 0xF4 with a device model clocking at 12.5 kHz and giving ACK:
  - CLK held low 6000 cycles, then data low 100 cycles, then clock released.
  - Device-sampled bits are 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - ACK low → single BYTE_SENT pulse, ERROR_CODE=00.
- Send 0xFF → device samples parity 1. With the model withholding ACK (data high at edge 11) → BYTE_SENT pulse, ERROR_CODE=10.
- Device never clocks after release → BYTE_SENT exactly START_TIMEOUT (+ sync latency) cycles after release, ERROR_CODE=01, lines released.
- Device stops after edge 5 → timeout after BIT_TIMEOUT cycles, ERROR_CODE=01.
- Issue SEND_BYTE=0x00 during an ongoing 0xF4 transfer → ignored; the frame still carries 0xF4, and exactly one BYTE_SENT pulse occurs.
